// File: rtl/lab5_pkg.sv
// Shared ASCII constants and the lower-to-upper case helper for the UART line path.
package lab5_pkg;

    localparam logic [7:0] CHAR_CR     = 8'h0D;
    localparam logic [7:0] CHAR_LC_A   = 8'h61;
    localparam logic [7:0] CHAR_LC_Z   = 8'h7A;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

    function automatic logic [7:0] to_upper(input logic [7:0] b);
        if ((b >= CHAR_LC_A) && (b <= CHAR_LC_Z)) begin
            return b - CASE_OFFSET;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/rx_line_buffer_byte_fifo.sv
// byte_fifo: first-word-fall-through byte storage with registered count/empty/full.
module byte_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          wr_ok,
    output logic          rd_ok,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          empty_r;
    logic          full_r;
    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] count_next_s;

    // Qualify requests against the flags and compute the next occupancy
    always_comb begin
        push_s       = wr_en && !full_r;
        pop_s        = rd_en && !empty_r;
        count_next_s = count_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + CW'(1);
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Storage array; contents survive reset, only the pointers are cleared
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
            empty_r <= (count_next_s == CW'(0));
            full_r  <= (count_next_s == CW'(DEPTH));
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign wr_ok   = push_s;
    assign rd_ok   = pop_s;
    assign empty   = empty_r;
    assign full    = full_r;
    assign count   = count_r;

endmodule

// File: rtl/rx_line_buffer.sv
// UART receive line buffer: case conversion, CR line counting and sticky overflow around byte_fifo.
// Optional upper-case conversion is enabled by defining RX_UPCASE_EN.
module rx_line_buffer
    import lab5_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          received,
    input  logic [7:0]    rx_byte,
    input  logic          recv_error,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          line_ready,
    output logic          overflow
);

    logic [7:0]    wr_byte_s;
    logic          wr_req_s;
    logic          wr_ok_s;
    logic          rd_ok_s;
    logic [CW-1:0] lines_r;
    logic [CW-1:0] lines_next_s;
    logic          line_ready_r;
    logic          overflow_r;

`ifdef RX_UPCASE_EN
    assign wr_byte_s = to_upper(rx_byte);
`else
    assign wr_byte_s = rx_byte;
`endif

    assign wr_req_s = received && !recv_error;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_req_s),
        .wr_data (wr_byte_s),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .wr_ok   (wr_ok_s),
        .rd_ok   (rd_ok_s),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

    // A CR written and a CR popped in the same cycle cancel out
    always_comb begin
        lines_next_s = lines_r;
        if ((wr_ok_s && (wr_byte_s == CHAR_CR)) && !(rd_ok_s && (rd_data == CHAR_CR))) begin
            lines_next_s = lines_r + CW'(1);
        end else if (!(wr_ok_s && (wr_byte_s == CHAR_CR)) && (rd_ok_s && (rd_data == CHAR_CR))) begin
            lines_next_s = lines_r - CW'(1);
        end else begin
            lines_next_s = lines_r;
        end
    end

    // Line counter, line_ready flag and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            lines_r      <= '0;
            line_ready_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            lines_r      <= lines_next_s;
            line_ready_r <= (lines_next_s != CW'(0));
            overflow_r   <= overflow_r || (wr_req_s && full);
        end
    end

    assign line_ready = line_ready_r;
    assign overflow   = overflow_r;

endmodule

// File: doc/rx_line_buffer.md
RX_LINE_BUFFER -- requirements
Module: rx_line_buffer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in bytes; SHALL be a power of two, 4..256.
REQ-002 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 received  input  1  one-cycle strobe from the UART receiver: rx_byte valid.
REQ-005 rx_byte  input  8  received byte.
REQ-006 recv_error  input  1  UART framing error, qualifies received.
REQ-007 rd_en  input  1  pop request from the transmit controller.
REQ-008 rd_data  output  8  head byte (first-word-fall-through), valid while empty=0.
REQ-009 empty  output  1  FIFO holds no bytes.
REQ-010 full  output  1  FIFO holds DEPTH bytes.
REQ-011 count  output  $clog2(DEPTH)+1  bytes currently stored, 0..DEPTH.
REQ-012 line_ready  output  1  at least one stored CR (8'h0D) not yet popped.
REQ-013 overflow  output  1  sticky: a byte was dropped because the FIFO was full.

Function
REQ-014 Write SHALL occur when received=1, recv_error=0 and full=0; the stored byte is the converted byte (REQ-020).
REQ-015 received=1 with recv_error=1 SHALL drop the byte, with no change to any output.
REQ-016 received=1 with recv_error=0 while full=1 SHALL drop the byte and set overflow on the next edge, even if rd_en=1 in the same cycle.
REQ-017 Pop SHALL occur when rd_en=1 and empty=0; rd_en while empty SHALL be ignored.
REQ-018 Simultaneous write and pop SHALL leave count unchanged and advance both pointers.
REQ-019 Pointers SHALL wrap modulo DEPTH; count, empty and full SHALL be registered and updated on the edge of the write or pop (zero-cycle read latency; write visible on rd_data one cycle after the received strobe).
REQ-020 Conversion: bytes 8'h61..8'h7A SHALL be stored minus 8'h20; all other bytes SHALL be stored unchanged.
REQ-021 A lines counter (0..DEPTH) SHALL increment on a write of 8'h0D and decrement on a pop of 8'h0D; both in the same cycle SHALL leave it unchanged; line_ready = (lines != 0).
REQ-022 overflow SHALL clear only on reset.
REQ-023 A write and a pop of the same entry SHALL NOT happen in one cycle (empty blocks the pop); no bypass path.

Reset
REQ-024 While reset=1: pointers=0, count=0, lines=0, empty=1, full=0, line_ready=0, overflow=0; rd_data is don't-care.
REQ-025 Reset mid-stream SHALL discard all stored bytes; memory contents need not be cleared.
REQ-026 received or rd_en asserted in the reset cycle SHALL be ignored.

Configuration
REQ-027 Macro RX_UPCASE_EN: when defined, REQ-020 conversion applies; when undefined, bytes SHALL be stored unchanged, with all other behaviour identical.

Structure
REQ-028 Shared package lab5_pkg SHALL hold the ASCII constants CHAR_CR=8'h0D, CHAR_LC_A=8'h61, CHAR_LC_Z=8'h7A, CASE_OFFSET=8'h20.
REQ-029 Sub-module byte_fifo (storage, pointers, count, flags) SHALL be instantiated; conversion, line counting and overflow SHALL live in rx_line_buffer.

Verification (DEPTH=16)
REQ-030 Write "ab1\r" (61,62,31,0D) -> pops return 41,42,31,0D; line_ready=1 after the 4th write and 0 after the 4th pop.
REQ-031 17 writes of 8'h55 without pops -> full=1 and count=16 after 16 writes; 17th write dropped, overflow=1; 16 pops return 55, then empty=1.
REQ-032 Hold count=5, then drive received and rd_en together for 20 cycles -> count stays 5, data order is preserved, and pointers wrap without error.
REQ-033 received=1 with recv_error=1 and rx_byte=8'h41 -> count is unchanged and empty stays 1.
REQ-034 Write 3 bytes, then pulse reset in the middle of a 2nd burst -> after reset: empty=1, count=0, overflow=0, line_ready=0; the next write is readable normally.
REQ-035 Build without RX_UPCASE_EN and write 8'h7A -> pop returns 8'h7A.
